// File: rtl/sparc_control_unit_pkg.sv
// ============================================================================
// sparc_ctrl_pkg : shared encodings for the SPARC control unit   (rev 1.0)
// ============================================================================
`default_nettype none

package sparc_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET      = 4'd0,
    FETCH      = 4'd1,
    FETCH_WAIT = 4'd2,
    DECODE     = 4'd3,
    EXEC       = 4'd4,
    LS_ADDR    = 4'd5,
    LD_WAIT    = 4'd6,
    LD_WB      = 4'd7,
    ST_DATA    = 4'd8,
    ST_WAIT    = 4'd9,
    BRANCH     = 4'd10,
    UPDATE     = 4'd11,
    ERROR      = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_MEM     = 3'd1,
    CL_BRANCH  = 3'd2,
    CL_NOP     = 3'd3,
    CL_ILLEGAL = 3'd4
  } iclass_e;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_PASSB = 6'b011111;

  // Bit positions inside Ld = {IR,MAR,MDR,PC,NPC,FR,RF}
  localparam int LDB_IR  = 6;
  localparam int LDB_MAR = 5;
  localparam int LDB_MDR = 4;
  localparam int LDB_PC  = 3;
  localparam int LDB_NPC = 2;
  localparam int LDB_FR  = 1;
  localparam int LDB_RF  = 0;

  localparam logic [1:0] TYPE_WORD = 2'b00;
  localparam logic [1:0] TYPE_BYTE = 2'b01;
  localparam logic [1:0] TYPE_HALF = 2'b10;

endpackage

`default_nettype wire

// File: rtl/sparc_control_unit_if.sv
// ============================================================================
// sparc_control_unit_if : control unit <-> DataPath/RAM signal bundle (rev 1.0)
// ============================================================================
`default_nettype none

interface sparc_control_unit_if;
  logic [31:0] IR;
  logic        MOC;
  logic        BCOND;
  logic [6:0]  Ld;
  logic        nPC_Clr;
  logic        MOV;
  logic        RW;
  logic [1:0]  Type;
  logic [1:0]  MA;
  logic [1:0]  MB;
  logic        MC;
  logic        MM;
  logic [1:0]  MNP;
  logic        MOP;
  logic [1:0]  MP;
  logic [1:0]  MSc;
  logic [5:0]  OpXX;
  logic [3:0]  State;

  modport master (
    input  IR, MOC, BCOND,
    output Ld, nPC_Clr, MOV, RW, Type, MA, MB, MC, MM, MNP, MOP, MP, MSc, OpXX, State
  );

  modport slave (
    output IR, MOC, BCOND,
    input  Ld, nPC_Clr, MOV, RW, Type, MA, MB, MC, MM, MNP, MOP, MP, MSc, OpXX, State
  );
endinterface

`default_nettype wire

// File: rtl/sparc_control_unit_decoder.sv
// ============================================================================
// sparc_ctrl_decoder : classifies the fetched instruction word     (rev 1.0)
// ============================================================================
`default_nettype none

module sparc_ctrl_decoder
  import sparc_ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output iclass_e     class_o,
  output logic        is_store_o,
  output logic [1:0]  size_o,
  output logic        sets_cc_o
);

  logic [5:0] op3;
  logic [2:0] op2;
  logic       unused_ir;

  assign op3        = ir_i[24:19];
  assign op2        = ir_i[24:22];
  assign is_store_o = op3[2];
  assign size_o     = op3[1:0];
  assign sets_cc_o  = op3[4];
  assign unused_ir  = ^{ir_i[29:25], ir_i[18:0]};

  always_comb begin
    class_o = CL_ILLEGAL;
    unique case (ir_i[31:30])
      2'b10: class_o = CL_ALU;
      2'b11: begin
        if (op3 inside {6'b000000, 6'b000001, 6'b000010,
                        6'b000100, 6'b000101, 6'b000110})
          class_o = CL_MEM;
      end
      2'b00: begin
        if (op2 == 3'b010)      class_o = CL_BRANCH;
        else if (op2 == 3'b100) class_o = CL_NOP;
      end
      default: class_o = CL_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sparc_control_unit.sv
// ============================================================================
// sparc_control_unit : hardwired FSM sequencing the SPARC DataPath  (rev 1.0)
// ============================================================================
`default_nettype none

module sparc_control_unit
  import sparc_ctrl_pkg::*;
#(
  parameter int MOC_TIMEOUT     = 15,
  parameter int RESET_PC_CYCLES = 1
) (
  input  logic                 Clk,
  input  logic                 Clr,
  sparc_control_unit_if.master bus
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  iclass_e    dec_class;
  logic       dec_store;
  logic [1:0] dec_size;
  logic       dec_cc;

  sparc_ctrl_decoder u_dec (
    .ir_i      (bus.IR),
    .class_o   (dec_class),
    .is_store_o(dec_store),
    .size_o    (dec_size),
    .sets_cc_o (dec_cc)
  );

  assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign bus.MA    = 2'b00;
  assign bus.MSc   = 2'b00;
  assign bus.State = state_q;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= RESET;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_d defaults to zero, so the counter is cleared on entry to every state
  always_comb begin
    state_d     = state_q;
    cnt_d       = 4'd0;
    bus.Ld      = 7'd0;
    bus.nPC_Clr = 1'b0;
    bus.MOV     = 1'b0;
    bus.RW      = 1'b1;
    bus.Type    = TYPE_WORD;
    bus.MB      = 2'd0;
    bus.MC      = 1'b0;
    bus.MM      = 1'b0;
    bus.MNP     = 2'd0;
    bus.MOP     = 1'b0;
    bus.MP      = 2'd0;
    bus.OpXX    = 6'd0;
    if (Clr) begin
      bus.nPC_Clr = 1'b1;
    end else begin
      case (state_q)
        RESET: begin
          if (cnt_q < 4'(RESET_PC_CYCLES)) begin
            bus.Ld[LDB_PC] = 1'b1;
            bus.nPC_Clr    = 1'b1;
            cnt_d          = cnt_inc;
          end else begin
            bus.Ld[LDB_NPC] = 1'b1;
            bus.MNP         = 2'd3;
            state_d         = FETCH;
          end
        end
        FETCH: begin
          bus.MB          = 2'd2;
          bus.MOP         = 1'b1;
          bus.OpXX        = ALU_PASSB;
          bus.Ld[LDB_MAR] = 1'b1;
          state_d         = FETCH_WAIT;
        end
        FETCH_WAIT: begin
          bus.MOV        = 1'b1;
          bus.Ld[LDB_IR] = bus.MOC;
          if (bus.MOC)                              state_d = DECODE;
          else if (cnt_inc == 4'(MOC_TIMEOUT))      state_d = ERROR;
          else                                      cnt_d   = cnt_inc;
        end
        DECODE: begin
          case (dec_class)
            CL_ALU:    state_d = EXEC;
            CL_MEM:    state_d = LS_ADDR;
            CL_BRANCH: state_d = BRANCH;
            CL_NOP:    state_d = UPDATE;
            default:   state_d = ERROR;
          endcase
        end
        EXEC: begin
          bus.MB         = {1'b0, bus.IR[13]};
          bus.Ld[LDB_RF] = 1'b1;
          bus.Ld[LDB_FR] = dec_cc;
          state_d        = UPDATE;
        end
        LS_ADDR: begin
          bus.MOP         = 1'b1;
          bus.OpXX        = ALU_ADD;
          bus.MB          = {1'b0, bus.IR[13]};
          bus.Ld[LDB_MAR] = 1'b1;
          state_d         = dec_store ? ST_DATA : LD_WAIT;
        end
        LD_WAIT: begin
          bus.MOV         = 1'b1;
          bus.Type        = dec_size;
          bus.Ld[LDB_MDR] = bus.MOC;
          if (bus.MOC)                              state_d = LD_WB;
          else if (cnt_inc == 4'(MOC_TIMEOUT))      state_d = ERROR;
          else                                      cnt_d   = cnt_inc;
        end
        LD_WB: begin
          bus.MB         = 2'd3;
          bus.MOP        = 1'b1;
          bus.OpXX       = ALU_PASSB;
          bus.Ld[LDB_RF] = 1'b1;
          state_d        = UPDATE;
        end
        ST_DATA: begin
          bus.MOP         = 1'b1;
          bus.OpXX        = ALU_PASSB;
          bus.MM          = 1'b1;
          bus.Ld[LDB_MDR] = 1'b1;
          state_d         = ST_WAIT;
        end
        ST_WAIT: begin
          bus.MOV  = 1'b1;
          bus.RW   = 1'b0;
          bus.Type = dec_size;
          if (bus.MOC)                              state_d = UPDATE;
          else if (cnt_inc == 4'(MOC_TIMEOUT))      state_d = ERROR;
          else                                      cnt_d   = cnt_inc;
        end
        BRANCH, UPDATE: begin
          bus.Ld[LDB_PC]  = 1'b1;
          bus.Ld[LDB_NPC] = 1'b1;
          bus.MP          = 2'd3;
          bus.MNP         = (state_q == BRANCH && bus.BCOND) ? 2'd2 : 2'd3;
          state_d         = FETCH;
        end
        ERROR:   state_d = ERROR;
        default: state_d = ERROR;
      endcase
    end
  end

endmodule

`default_nettype wire
